// File: rtl/sync_fifo.sv
// sync_fifo: single-clock 8 x 32-bit FIFO with a registered read port and
// per-request acknowledge/error strobes that appear one cycle after the
// request. The strobes are decoded from a small state register that records
// what the previous cycle's request turned into.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [CNT_WIDTH-1:0]  data_count
);

    // Outcome of the previous cycle's request pair. The combined states cover
    // simultaneous read/write requests, where both strobes fire together.
    typedef enum logic [3:0] {
        INIT,
        NO_OP,
        WRITE,
        READ,
        WR_ERROR,
        RD_ERROR,
        WRITE_READ,
        WRITE_RD_ERROR,
        READ_WR_ERROR
    } fifoState_e;

    fifoState_e state_q, state_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  head_q, head_d;
    logic [PTR_WIDTH-1:0]  tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic wrAccept;
    logic rdAccept;

    assign full     = (count_q == CNT_WIDTH'(DEPTH));
    assign empty    = (count_q == '0);
    assign wrAccept = wr_en && !full;
    assign rdAccept = rd_en && !empty;

    assign dout       = dout_q;
    assign data_count = count_q;

    // Next pointers, occupancy and read data from the accepted operations.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (wrAccept) begin
            tail_d = tail_q + PTR_WIDTH'(1);
        end
        if (rdAccept) begin
            head_d = head_q + PTR_WIDTH'(1);
            dout_d = mem_q[head_q];
        end
        case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and read-data registers; reset drops all queued data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage array; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem_q[tail_q] <= din;
        end
    end

    // State register holding the classified outcome of the last request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Classify this cycle's requests against the current full/empty flags.
    always_comb begin
        state_d = NO_OP;
        case ({wr_en, rd_en})
            2'b10:   state_d = full  ? WR_ERROR : WRITE;
            2'b01:   state_d = empty ? RD_ERROR : READ;
            2'b11: begin
                if (empty) begin
                    state_d = WRITE_RD_ERROR;
                end else if (full) begin
                    state_d = READ_WR_ERROR;
                end else begin
                    state_d = WRITE_READ;
                end
            end
            default: state_d = NO_OP;
        endcase
    end

    // Decode the registered outcome into the one-cycle strobes.
    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state_q)
            WRITE:          wr_ack = 1'b1;
            READ:           rd_ack = 1'b1;
            WR_ERROR:       wr_err = 1'b1;
            RD_ERROR:       rd_err = 1'b1;
            WRITE_READ: begin
                wr_ack = 1'b1;
                rd_ack = 1'b1;
            end
            WRITE_RD_ERROR: begin
                wr_ack = 1'b1;
                rd_err = 1'b1;
            end
            READ_WR_ERROR: begin
                rd_ack = 1'b1;
                wr_err = 1'b1;
            end
            default: begin
                wr_ack = 1'b0;
                wr_err = 1'b0;
                rd_ack = 1'b0;
                rd_err = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives directed and randomized request patterns into sync_fifo
// and compares every output against a queue-based reference model.
module tb_sync_fifo;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [31:0] din;
    logic        rd_en;
    logic [31:0] dout;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [3:0]  data_count;

    int testsRun;
    int testsFailed;

    logic [31:0] modelQ [$];
    logic [31:0] expDout;
    logic        expWrAck;
    logic        expWrErr;
    logic        expRdAck;
    logic        expRdErr;

    sync_fifo #(
        .DATA_WIDTH(32),
        .DEPTH(8),
        .PTR_WIDTH(3),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .din(din),
        .rd_en(rd_en),
        .dout(dout),
        .full(full),
        .empty(empty),
        .wr_ack(wr_ack),
        .wr_err(wr_err),
        .rd_ack(rd_ack),
        .rd_err(rd_err),
        .data_count(data_count)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output against the model's current expectations.
    task automatic checkAll(input string tag);
        int cnt;
        cnt = modelQ.size();
        checkOutput($sformatf("%s.dout", tag), dout, expDout);
        checkOutput($sformatf("%s.count", tag), 32'(data_count), 32'(cnt));
        checkOutput($sformatf("%s.full", tag), 32'(full), 32'(cnt == 8));
        checkOutput($sformatf("%s.empty", tag), 32'(empty), 32'(cnt == 0));
        checkOutput($sformatf("%s.wr_ack", tag), 32'(wr_ack), 32'(expWrAck));
        checkOutput($sformatf("%s.wr_err", tag), 32'(wr_err), 32'(expWrErr));
        checkOutput($sformatf("%s.rd_ack", tag), 32'(rd_ack), 32'(expRdAck));
        checkOutput($sformatf("%s.rd_err", tag), 32'(rd_err), 32'(expRdErr));
    endtask

    // Clear the model to its post-reset view.
    task automatic modelReset();
        modelQ.delete();
        expDout  = 32'h0;
        expWrAck = 1'b0;
        expWrErr = 1'b0;
        expRdAck = 1'b0;
        expRdErr = 1'b0;
    endtask

    // Drive one request cycle (called just after a rising edge), advance the
    // model by the FIFO rules, then check all outputs after the next edge.
    task automatic applyStimulus(input logic wr, input logic rd,
                                 input logic [31:0] data, input string tag);
        int cnt;
        wr_en = wr;
        rd_en = rd;
        din   = data;
        cnt = modelQ.size();
        expWrAck = wr && (cnt < 8);
        expWrErr = wr && (cnt == 8);
        expRdAck = rd && (cnt > 0);
        expRdErr = rd && (cnt == 0);
        if (expRdAck) expDout = modelQ.pop_front();
        if (expWrAck) modelQ.push_back(data);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        checkAll(tag);
    endtask

    initial begin
        int bias;
        testsRun    = 0;
        testsFailed = 0;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = 32'h0;
        modelReset();

        // Reset, then an idle cycle.
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkAll("reset");
        applyStimulus(1'b0, 1'b0, 32'h0, "idle");

        // Fill with 0x11111111..0x88888888, then one write too many.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h11111111 * i, $sformatf("fill%0d", i));
        end
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, "overfill");

        // Drain nine times; the last read is rejected and dout holds.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h0, $sformatf("drain%0d", i));
        end
        applyStimulus(1'b0, 1'b0, 32'h0, "idleAfterDrain");

        // Wrap the pointers: write 5, read 5, write 6, read 6.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'hA000_0000 + i, "wrapW5");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 32'h0, "wrapR5");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'hB000_0000 + i, "wrapW6");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 32'h0, "wrapR6");

        // Simultaneous read/write at count 3, at empty and at full.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'hC000_0000 + i, "mid");
        applyStimulus(1'b1, 1'b1, 32'hC0DE0003, "rwMid");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h0, "midDrain");
        applyStimulus(1'b1, 1'b1, 32'hE0E0E0E0, "rwEmpty");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 32'hF000_0000 + i, "topUp");
        applyStimulus(1'b1, 1'b1, 32'hBADBAD00, "rwFull");

        // Bring occupancy to 5, then reset between edges.
        applyStimulus(1'b0, 1'b1, 32'h0, "toSix");
        applyStimulus(1'b0, 1'b1, 32'h0, "toFive");
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll("asyncReset");
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("postReset");
        applyStimulus(1'b0, 1'b1, 32'h0, "readAfterReset");

        // Randomized traffic with phases that bias toward filling or draining.
        for (int phase = 0; phase < 6; phase++) begin
            bias = (phase % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 60; i++) begin
                applyStimulus(($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
                              ($urandom_range(0, 99) >= bias) ? 1'b1 : 1'b0,
                              $urandom, $sformatf("rand%0d", phase));
            end
        end
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, "randMix");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
